// File: rtl/fight_pkg.sv
// rtl/fight_pkg.sv - shared action codes, FSM state encodings and priority helper
//
// Shared between action_encoder and the player FSMs.
//   action_t     : encoded player action (kick 000, punch 001, wait 010,
//                  jump 011, left 100, right 101)
//   enc_state_t  : action_encoder FSM states
//   pick_action  : highest-priority action from a vector of press events
package fight_pkg;

    localparam int NUM_BTNS  = 5;
    localparam int BTN_KICK  = 0;
    localparam int BTN_PUNCH = 1;
    localparam int BTN_JUMP  = 2;
    localparam int BTN_LEFT  = 3;
    localparam int BTN_RIGHT = 4;

    typedef enum logic [2:0] {
        ACT_KICK  = 3'b000,
        ACT_PUNCH = 3'b001,
        ACT_WAIT  = 3'b010,
        ACT_JUMP  = 3'b011,
        ACT_LEFT  = 3'b100,
        ACT_RIGHT = 3'b101
    } action_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_PRESENT = 2'b10
    } enc_state_t;

    // Priority kick > punch > jump > left > right; ACT_WAIT when nothing pressed.
    function automatic action_t pick_action(input logic [NUM_BTNS-1:0] press);
        action_t result;
        if (press[BTN_KICK])
            result = ACT_KICK;
        else if (press[BTN_PUNCH])
            result = ACT_PUNCH;
        else if (press[BTN_JUMP])
            result = ACT_JUMP;
        else if (press[BTN_LEFT])
            result = ACT_LEFT;
        else if (press[BTN_RIGHT])
            result = ACT_RIGHT;
        else
            result = ACT_WAIT;
        return result;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-button debouncer with rising-edge pulse
//
// Ports:
//   clk   : clock, all logic on posedge
//   rst   : synchronous active-high reset
//   btn   : raw button sample
//   level : debounced level
//   rise  : one-cycle pulse in the first cycle the debounced level is high
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // cnt holds how many consecutive samples have disagreed with level so far;
    // the sample that would make it DEBOUNCE_CYCLES flips level instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (btn == level) begin
                cnt <= '0;
            end else if (cnt == TERMINAL) begin
                level <= btn;
                cnt   <= '0;
                rise  <= btn;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/action_encoder.sv
// rtl/action_encoder.sv - debounces five buttons and encodes one action per round
//
// Ports:
//   clk          : clock, all logic on posedge
//   rst          : synchronous active-high reset
//   btn[4:0]     : raw buttons (kick, punch, jump, left, right)
//   round_start  : pulse opening a collection window (IDLE only)
//   action_ready : consumer accepts the presented action
//   action[2:0]  : encoded action (fight_pkg::action_t)
//   action_valid : action presented and stable
//   timed_out    : presented action is the default wait from window expiry
//   busy         : collecting or presenting
module action_encoder
    import fight_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ROUND_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] btn,
    input  logic       round_start,
    input  logic       action_ready,
    output logic [2:0] action,
    output logic       action_valid,
    output logic       timed_out,
    output logic       busy
);

    localparam int RW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
    localparam logic [RW-1:0] ROUND_LAST = RW'(ROUND_CYCLES - 1);

    logic [NUM_BTNS-1:0] level;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] press;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn[i]),
            .level(level[i]),
            .rise (rise[i])
        );
    end

    // A press is a fresh 0->1 of the debounced level; buttons already held
    // when the window opens never produce one.
    assign press = rise & level;

    enc_state_t    state;
    logic [RW-1:0] round_cnt;
    action_t       action_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            round_cnt    <= '0;
            action_q     <= ACT_WAIT;
            action_valid <= 1'b0;
            timed_out    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (round_start) begin
                        state     <= ST_COLLECT;
                        round_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    // A press on the last window cycle still beats the timeout.
                    if (|press) begin
                        action_q     <= pick_action(press);
                        timed_out    <= 1'b0;
                        action_valid <= 1'b1;
                        state        <= ST_PRESENT;
                    end else if (round_cnt == ROUND_LAST) begin
                        action_q     <= ACT_WAIT;
                        timed_out    <= 1'b1;
                        action_valid <= 1'b1;
                        state        <= ST_PRESENT;
                    end else begin
                        round_cnt <= round_cnt + 1'b1;
                    end
                end
                ST_PRESENT: begin
                    if (action_ready) begin
                        state        <= ST_IDLE;
                        action_q     <= ACT_WAIT;
                        timed_out    <= 1'b0;
                        action_valid <= 1'b0;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign action = action_q;

endmodule

// File: tb/tb_action_encoder.sv
// tb/tb_action_encoder.sv - self-checking bench for action_encoder
module tb_action_encoder;

    localparam int D = 4;
    localparam int R = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] btn = 5'b0;
    logic       round_start = 1'b0;
    logic       action_ready = 1'b0;
    logic [2:0] action;
    logic       action_valid;
    logic       timed_out;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // {busy, action_valid, timed_out, action}
    wire [5:0] obs = {busy, action_valid, timed_out, action};

    always #5 clk = ~clk;

    action_encoder #(
        .DEBOUNCE_CYCLES(D),
        .ROUND_CYCLES(R)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .round_start (round_start),
        .action_ready(action_ready),
        .action      (action),
        .action_valid(action_valid),
        .timed_out   (timed_out),
        .busy        (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Release all buttons long enough for every debounced level to drop.
    task automatic settle();
        btn = 5'b0;
        round_start = 1'b0;
        action_ready = 1'b0;
        ticks(D + 2);
    endtask

    // ---------------- reference model ----------------
    // Level follows a button once its last D samples all disagree with it.
    // Captures use press events produced by the previous edge.
    int         m_phase;          // 0 idle, 1 collecting, 2 presenting
    int         m_elapsed;
    logic [2:0] m_act;
    logic       m_to;
    logic [4:0] m_level;
    logic [4:0] m_rise;
    logic [4:0] m_hist [D];
    int         code_of [5] = '{0, 1, 3, 4, 5};

    task automatic model_step(input logic r, input logic rs, input logic rdy, input logic [4:0] b);
        bit all_differ;
        if (r) begin
            m_phase = 0; m_elapsed = 0; m_act = 3'b010; m_to = 1'b0;
            m_level = '0; m_rise = '0;
            for (int k = 0; k < D; k++) m_hist[k] = '0;
            return;
        end
        case (m_phase)
            0: if (rs) begin m_phase = 1; m_elapsed = 0; end
            1: begin
                if (m_rise != 5'b0) begin
                    for (int k = 4; k >= 0; k--) if (m_rise[k]) m_act = 3'(code_of[k]);
                    m_to = 1'b0; m_phase = 2;
                end else if (m_elapsed == R - 1) begin
                    m_act = 3'b010; m_to = 1'b1; m_phase = 2;
                end else begin
                    m_elapsed++;
                end
            end
            default: if (rdy) begin m_phase = 0; m_act = 3'b010; m_to = 1'b0; end
        endcase
        for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = b;
        m_rise = '0;
        for (int i = 0; i < 5; i++) begin
            all_differ = 1'b1;
            for (int k = 0; k < D; k++) if (m_hist[k][i] == m_level[i]) all_differ = 1'b0;
            if (all_differ) begin
                m_rise[i]  = ~m_level[i];
                m_level[i] = ~m_level[i];
            end
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL reset_state: got %b want %b", obs, 6'b000010); end
    endtask

    task automatic test_punch();
        rst = 1'b1; tick(); rst = 1'b0;
        round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 5'b00010; ticks(D);
        vectors++;
        if (obs !== 6'b100010) begin miscompares++; $display("FAIL punch_rise_cycle: got %b want %b", obs, 6'b100010); end
        tick();
        vectors++;
        if (obs !== 6'b110001) begin miscompares++; $display("FAIL punch_present: got %b want %b", obs, 6'b110001); end
        action_ready = 1'b1; tick(); action_ready = 1'b0;
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL punch_handshake: got %b want %b", obs, 6'b000010); end
        settle();
    endtask

    task automatic test_priority();
        round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 5'b10001; ticks(D + 1);
        vectors++;
        if (obs !== 6'b110000) begin miscompares++; $display("FAIL kick_priority: got %b want %b", obs, 6'b110000); end
        action_ready = 1'b1; tick(); action_ready = 1'b0;
        settle();
    endtask

    task automatic test_timeout();
        round_start = 1'b1; tick(); round_start = 1'b0;
        ticks(R - 1);
        vectors++;
        if (obs !== 6'b100010) begin miscompares++; $display("FAIL timeout_early: got %b want %b", obs, 6'b100010); end
        tick();
        vectors++;
        if (obs !== 6'b111010) begin miscompares++; $display("FAIL timeout_present: got %b want %b", obs, 6'b111010); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (obs !== 6'b111010) begin miscompares++; $display("FAIL timeout_hold[%0d]: got %b want %b", i, obs, 6'b111010); end
        end
        action_ready = 1'b1; tick(); action_ready = 1'b0;
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL timeout_handshake: got %b want %b", obs, 6'b000010); end
    endtask

    task automatic test_glitch();
        round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 5'b00100; ticks(D - 1);
        btn = 5'b00000; ticks(3);
        vectors++;
        if (obs !== 6'b100010) begin miscompares++; $display("FAIL glitch_ignored: got %b want %b", obs, 6'b100010); end
        btn = 5'b00100; ticks(D + 1);
        vectors++;
        if (obs !== 6'b110011) begin miscompares++; $display("FAIL jump_present: got %b want %b", obs, 6'b110011); end
        action_ready = 1'b1; tick(); action_ready = 1'b0;
        settle();
    endtask

    task automatic test_held_button();
        btn = 5'b01000; ticks(D + 1);
        round_start = 1'b1; tick(); round_start = 1'b0;
        ticks(3);
        vectors++;
        if (obs !== 6'b100010) begin miscompares++; $display("FAIL held_no_event: got %b want %b", obs, 6'b100010); end
        btn = 5'b00000; ticks(D);
        btn = 5'b01000; ticks(D + 1);
        vectors++;
        if (obs !== 6'b110100) begin miscompares++; $display("FAIL left_present: got %b want %b", obs, 6'b110100); end
        round_start = 1'b1; tick(); round_start = 1'b0;
        vectors++;
        if (obs !== 6'b110100) begin miscompares++; $display("FAIL start_in_present: got %b want %b", obs, 6'b110100); end
        action_ready = 1'b1; round_start = 1'b1; tick(); action_ready = 1'b0; round_start = 1'b0;
        tick();
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL start_in_handshake: got %b want %b", obs, 6'b000010); end
        settle();
    endtask

    task automatic test_mid_reset();
        round_start = 1'b1; tick(); round_start = 1'b0;
        ticks(3);
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL reset_mid_collect: got %b want %b", obs, 6'b000010); end
        round_start = 1'b1; tick(); round_start = 1'b0;
        btn = 5'b00001; ticks(D + 1);
        btn = 5'b00000;
        vectors++;
        if (obs !== 6'b110000) begin miscompares++; $display("FAIL pre_reset_present: got %b want %b", obs, 6'b110000); end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL reset_mid_present: got %b want %b", obs, 6'b000010); end
        rst = 1'b1; round_start = 1'b1; tick(); rst = 1'b0; round_start = 1'b0;
        tick();
        vectors++;
        if (obs !== 6'b000010) begin miscompares++; $display("FAIL start_during_reset: got %b want %b", obs, 6'b000010); end
        settle();
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [4:0] b = 5'b0;
        logic [5:0] expected;
        int flip_rate = 8;
        int shown = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc % 250 == 0) flip_rate = int'($urandom_range(60, 3));
            for (int i = 0; i < 5; i++)
                if ($urandom_range(flip_rate - 1) == 0) b[i] = ~b[i];
            btn          = b;
            rst          = (cyc == 0) || ($urandom_range(299) == 0);
            round_start  = ($urandom_range(5) == 0);
            action_ready = ($urandom_range(2) == 0);
            model_step(rst, round_start, action_ready, btn);
            tick();
            expected = {m_phase != 0, m_phase == 2, m_to, m_act};
            vectors++;
            if (obs !== expected) begin
                miscompares++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: got %b want %b", cyc, obs, expected);
                end
            end
        end
        rst = 1'b0;
        settle();
    endtask

    initial begin
        tick();
        test_reset();
        test_punch();
        test_priority();
        test_timeout();
        test_glitch();
        test_held_button();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/action_encoder.md
ACTION_ENCODER -- requirements
Module: action_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive samples a button must hold a new level before the debounced level follows it.
REQ-002 Parameter ROUND_CYCLES, default 16, length of the collection window in clk cycles.
REQ-003 clk  input  1  single clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 btn  input  5  raw buttons: bit0 kick, bit1 punch, bit2 jump, bit3 left, bit4 right; active-high.
REQ-006 round_start  input  1  one-cycle pulse opening a collection window.
REQ-007 action_ready  input  1  consumer (player FSM) accepts action this cycle.
REQ-008 action  output  3  encoded action: kick 000, punch 001, wait 010, jump 011, left 100, right 101.
REQ-009 action_valid  output  1  action is valid and stable.
REQ-010 timed_out  output  1  valid action is a default wait caused by window expiry.
REQ-011 busy  output  1  high in COLLECT or PRESENT.

Function
REQ-012 Each button is debounced independently: its counter clears when btn equals the debounced level, else increments; on the cycle it would reach DEBOUNCE_CYCLES the debounced level takes btn and the counter clears.
REQ-013 A press event is a 0->1 transition of a debounced level (rise pulse, one cycle).
REQ-014 FSM states IDLE, COLLECT, PRESENT; reset state IDLE.
REQ-015 IDLE: round_start=1 -> COLLECT next cycle, round counter cleared to 0.
REQ-016 COLLECT: round counter increments each cycle; any rise pulse captures one action, priority kick > punch > jump > left > right, -> PRESENT.
REQ-017 COLLECT: counter at ROUND_CYCLES-1 with no rise pulse -> action=wait, timed_out=1, -> PRESENT.
REQ-018 Rise pulse and timeout in the same cycle: rise pulse wins, timed_out=0.
REQ-019 Buttons already debounced-high at COLLECT entry produce no event; a new rise is required.
REQ-020 Rise pulses outside COLLECT are discarded, never queued.
REQ-021 PRESENT: action_valid=1; action and timed_out held constant until action_valid & action_ready.
REQ-022 Handshake cycle in PRESENT -> IDLE next cycle; action_valid low in IDLE.
REQ-023 Latency: captured rise pulse in cycle N -> action_valid=1 in cycle N+1; action_ready already high in N+1 completes the handshake in N+1.
REQ-024 round_start in COLLECT or PRESENT is ignored; round_start in the handshake cycle is ignored.
REQ-025 action_ready outside PRESENT has no effect.
REQ-026 Counter widths sized from parameters with $clog2; no wrap possible before the terminal count.

Reset
REQ-027 rst=1 at any clock edge, including mid-COLLECT or mid-PRESENT, forces IDLE, action=wait (010), action_valid=0, timed_out=0, busy=0, all counters 0, all debounced levels 0.
REQ-028 rst overrides every other input in the same cycle; a round_start during rst is lost.

Structure
REQ-029 Action codes and FSM state encodings live in shared package fight_pkg, used also by the player FSMs.
REQ-030 Debounce logic is sub-module btn_debounce (one bit, parameter DEBOUNCE_CYCLES, outputs level and rise), instantiated five times.

Verification
REQ-031 rst, round_start, btn[1] high for 4 cycles in window -> action=001, action_valid the cycle after rise, timed_out=0; ready=1 -> IDLE.
REQ-032 round_start, btn[0] and btn[4] rise on the same cycle -> action=000 (kick priority).
REQ-033 round_start, no buttons for 16 cycles -> action=010, timed_out=1; hold ready=0 for 5 cycles -> outputs unchanged throughout.
REQ-034 btn[2] glitch high 3 cycles then low -> no capture; later 4-cycle hold -> action=011.
REQ-035 btn[3] held high before round_start -> no capture; release, re-press -> action=100; second round_start in PRESENT ignored.
REQ-036 rst asserted mid-COLLECT and mid-PRESENT -> next cycle IDLE, action_valid=0, action=010, busy=0.
